// File: rtl/riscv_v_lmul_sequencer.sv
// riscv_v_lmul_sequencer
// Breaks one decoded vector instruction with register grouping (LMUL 1/2/4/8)
// into per-register micro-ops and issues them one at a time to execute.
//
// Handshake: a transfer happens on a cycle where valid & ready are both high
// at the rising clock edge. A producer holding valid high keeps its payload
// stable until that transfer. in_ready is high only in IDLE; while ISSUE is
// active every out_* field holds until out_valid & out_ready.
module riscv_v_lmul_sequencer #(
  parameter int ADDR_W = 5,
  parameter int VL_W   = 11,
  parameter int ELOG_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_vlmul,
  input  logic [ELOG_W-1:0] in_elog,
  input  logic [VL_W-1:0]   in_vl,
  input  logic [VL_W-1:0]   in_vstart,
  input  logic [ADDR_W-1:0] in_vd,
  input  logic [ADDR_W-1:0] in_vs1,
  input  logic [ADDR_W-1:0] in_vs2,
  input  logic              in_is_reduct,
  input  logic              in_is_mask,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_vd,
  output logic [ADDR_W-1:0] out_vs1,
  output logic [ADDR_W-1:0] out_vs2,
  output logic [2:0]        out_uop_idx,
  output logic [VL_W-1:0]   out_elem_base,
  output logic [VL_W-1:0]   out_vstart,
  output logic              out_first,
  output logic              out_last,
  output logic              done,
  output logic              err_vstart_reduct,
  output logic              dbg_state
);

  typedef enum logic {IDLE = 1'b0, ISSUE = 1'b1} state_t;

  state_t state_q, state_d;

  // Latched instruction context
  logic [ADDR_W-1:0] vd_q, vs1_q, vs2_q;
  logic [ELOG_W-1:0] elog_q;
  logic [VL_W-1:0]   vs_q;
  logic [2:0]        kf_q, kl_q, k_q;
  logic              reduct_q, mask_q;
  logic              done_q, err_q;
  logic              done_d, err_d;

  // Accept-time decode
  logic [2:0]    n_m1;
  logic [VL_W:0] e_m1;
  logic [VL_W:0] ceil_cnt;
  logic [VL_W:0] kl_data;
  logic [VL_W:0] kl_full;
  logic [VL_W-1:0] vs_eff;
  logic [VL_W-1:0] kf_full;
  logic          empty;
  logic          accept, fire, is_first, is_last, load;

  // Group size minus one; fractional LMUL encodings behave as LMUL=1
  always_comb begin
    n_m1 = 3'd0;
    case (in_vlmul)
      3'd1:    n_m1 = 3'd1;
      3'd2:    n_m1 = 3'd3;
      3'd3:    n_m1 = 3'd7;
      default: n_m1 = 3'd0;
    endcase
  end

  // Element range of the instruction mapped onto register indices kf..kl
  always_comb begin
    vs_eff   = in_is_reduct ? '0 : in_vstart;
    e_m1     = ({{VL_W{1'b0}}, 1'b1} << in_elog) - 1'b1;
    ceil_cnt = ({1'b0, in_vl} + e_m1) >> in_elog;
    kl_data  = ceil_cnt - 1'b1;
    kl_full  = (kl_data < {{(VL_W-2){1'b0}}, n_m1}) ? kl_data
                                                    : {{(VL_W-2){1'b0}}, n_m1};
    kf_full  = vs_eff >> in_elog;
    empty    = (in_vl == '0) || (vs_eff >= in_vl) ||
               ({1'b0, kf_full} > kl_full);
  end

  assign accept   = in_valid && (state_q == IDLE);
  assign fire     = (state_q == ISSUE) && out_ready;
  assign is_first = (k_q == kf_q);
  assign is_last  = (k_q == kl_q);
  assign load     = !flush && accept && !empty;

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // Next state and one-cycle pulses; flush overrides accept and handshake
  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    if (flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            err_d = in_is_reduct && (in_vstart != '0);
            if (empty) done_d  = 1'b1;
            else       state_d = ISSUE;
          end
        end
        ISSUE: begin
          if (fire && is_last) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Instruction context latch and micro-op index advance
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vd_q     <= '0;
      vs1_q    <= '0;
      vs2_q    <= '0;
      elog_q   <= '0;
      vs_q     <= '0;
      kf_q     <= '0;
      kl_q     <= '0;
      k_q      <= '0;
      reduct_q <= 1'b0;
      mask_q   <= 1'b0;
    end else if (load) begin
      vd_q     <= in_vd;
      vs1_q    <= in_vs1;
      vs2_q    <= in_vs2;
      elog_q   <= in_elog;
      vs_q     <= vs_eff;
      kf_q     <= kf_full[2:0];
      kl_q     <= kl_full[2:0];
      k_q      <= kf_full[2:0];
      reduct_q <= in_is_reduct;
      mask_q   <= in_is_mask;
    end else if (!flush && fire && !is_last) begin
      k_q <= k_q + 3'd1;
    end
  end

  assign in_ready          = (state_q == IDLE);
  assign out_valid         = (state_q == ISSUE);
  assign dbg_state         = state_q;
  assign done              = done_q;
  assign err_vstart_reduct = err_q;
  assign out_uop_idx       = k_q;
  assign out_vd            = (mask_q || reduct_q) ? vd_q : vd_q + ADDR_W'(k_q);
  assign out_vs1           = reduct_q ? vs1_q : vs1_q + ADDR_W'(k_q);
  assign out_vs2           = vs2_q + ADDR_W'(k_q);
  assign out_elem_base     = VL_W'(k_q) << elog_q;
  assign out_vstart        = is_first ? (vs_q - out_elem_base) : '0;
  assign out_first         = out_valid && is_first;
  assign out_last          = out_valid && is_last;

endmodule

// File: tb/tb_riscv_v_lmul_sequencer.sv
// Directed bench for riscv_v_lmul_sequencer with hand-computed expectations.
module tb_riscv_v_lmul_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  in_vlmul = '0;
  logic [3:0]  in_elog = '0;
  logic [10:0] in_vl = '0;
  logic [10:0] in_vstart = '0;
  logic [4:0]  in_vd = '0, in_vs1 = '0, in_vs2 = '0;
  logic        in_is_reduct = 1'b0, in_is_mask = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [4:0]  out_vd, out_vs1, out_vs2;
  logic [2:0]  out_uop_idx;
  logic [10:0] out_elem_base, out_vstart;
  logic        out_first, out_last, done, err_vstart_reduct, dbg_state;

  int total = 0;
  int bad   = 0;

  // Packed view of a micro-op: valid, vd, vs1, vs2, idx, elem_base, vstart, first, last
  logic [42:0] obs;
  assign obs = {out_valid, out_vd, out_vs1, out_vs2, out_uop_idx,
                out_elem_base, out_vstart, out_first, out_last};

  riscv_v_lmul_sequencer dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_vlmul(in_vlmul), .in_elog(in_elog), .in_vl(in_vl), .in_vstart(in_vstart),
    .in_vd(in_vd), .in_vs1(in_vs1), .in_vs2(in_vs2),
    .in_is_reduct(in_is_reduct), .in_is_mask(in_is_mask),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_vd(out_vd), .out_vs1(out_vs1), .out_vs2(out_vs2),
    .out_uop_idx(out_uop_idx), .out_elem_base(out_elem_base),
    .out_vstart(out_vstart), .out_first(out_first), .out_last(out_last),
    .done(done), .err_vstart_reduct(err_vstart_reduct), .dbg_state(dbg_state)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer one instruction for exactly one cycle (accepted if in_ready)
  task automatic issue_instr(input logic [2:0] vlmul, input logic [3:0] elog,
                             input logic [10:0] vl, input logic [10:0] vstart,
                             input logic [4:0] vd, input logic [4:0] vs1,
                             input logic [4:0] vs2, input logic red, input logic mask);
    in_vlmul = vlmul; in_elog = elog; in_vl = vl; in_vstart = vstart;
    in_vd = vd; in_vs1 = vs1; in_vs2 = vs2; in_is_reduct = red; in_is_mask = mask;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    step(); step();
    total++;
    if (obs !== 43'd0) begin
      bad++; $display("FAIL reset_outputs got=%h exp=%h", obs, 43'd0);
    end
    total++;
    if ({in_ready, done, err_vstart_reduct} !== 3'b100) begin
      bad++; $display("FAIL reset_ctrl got=%b exp=100", {in_ready, done, err_vstart_reduct});
    end
    rst = 1'b1;
    step();
  endtask

  task automatic test_lmul4();
    logic [42:0] exp;
    issue_instr(3'd2, 4'd2, 11'd16, 11'd0, 5'd8, 5'd4, 5'd12, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      exp = {1'b1, 5'(8 + k), 5'(4 + k), 5'(12 + k), 3'(k), 11'(4 * k), 11'd0,
             (k == 0), (k == 3)};
      total++;
      if (obs !== exp) begin
        bad++; $display("FAIL lmul4_uop%0d got=%h exp=%h", k, obs, exp);
      end
      step();
    end
    total++;
    if ({done, out_valid, in_ready} !== 3'b101) begin
      bad++; $display("FAIL lmul4_done got=%b exp=101", {done, out_valid, in_ready});
    end
    step();
    total++;
    if (done !== 1'b0) begin
      bad++; $display("FAIL lmul4_done_pulse got=%b exp=0", done);
    end
  endtask

  task automatic test_vstart();
    logic [42:0] exp;
    issue_instr(3'd3, 4'd3, 11'd20, 11'd10, 5'd0, 5'd8, 5'd16, 1'b0, 1'b0);
    for (int k = 1; k < 3; k++) begin
      exp = {1'b1, 5'(k), 5'(8 + k), 5'(16 + k), 3'(k), 11'(8 * k),
             (k == 1) ? 11'd2 : 11'd0, (k == 1), (k == 2)};
      total++;
      if (obs !== exp) begin
        bad++; $display("FAIL vstart_uop%0d got=%h exp=%h", k, obs, exp);
      end
      step();
    end
    total++;
    if ({done, out_valid} !== 2'b10) begin
      bad++; $display("FAIL vstart_done got=%b exp=10", {done, out_valid});
    end
    step();
  endtask

  task automatic test_reduct();
    logic [42:0] exp;
    issue_instr(3'd1, 4'd3, 11'd16, 11'd5, 5'd1, 5'd2, 5'd30, 1'b1, 1'b0);
    total++;
    if (err_vstart_reduct !== 1'b1) begin
      bad++; $display("FAIL reduct_err got=%b exp=1", err_vstart_reduct);
    end
    for (int k = 0; k < 2; k++) begin
      exp = {1'b1, 5'd1, 5'd2, 5'(30 + k), 3'(k), 11'(8 * k), 11'd0, (k == 0), (k == 1)};
      total++;
      if (obs !== exp) begin
        bad++; $display("FAIL reduct_uop%0d got=%h exp=%h", k, obs, exp);
      end
      step();
      if (k == 0) begin
        total++;
        if (err_vstart_reduct !== 1'b0) begin
          bad++; $display("FAIL reduct_err_pulse got=%b exp=0", err_vstart_reduct);
        end
      end
    end
    total++;
    if (done !== 1'b1) begin
      bad++; $display("FAIL reduct_done got=%b exp=1", done);
    end
    step();
  endtask

  task automatic test_empty();
    issue_instr(3'd2, 4'd2, 11'd0, 11'd0, 5'd3, 5'd4, 5'd5, 1'b0, 1'b0);
    total++;
    if ({out_valid, done, in_ready} !== 3'b011) begin
      bad++; $display("FAIL empty_t1 got=%b exp=011", {out_valid, done, in_ready});
    end
    step();
    total++;
    if ({out_valid, done, in_ready} !== 3'b001) begin
      bad++; $display("FAIL empty_t2 got=%b exp=001", {out_valid, done, in_ready});
    end
  endtask

  task automatic test_stall_flush();
    logic [42:0] exp;
    out_ready = 1'b0;
    issue_instr(3'd1, 4'd2, 11'd8, 11'd0, 5'd4, 5'd6, 5'd10, 1'b0, 1'b0);
    exp = {1'b1, 5'd4, 5'd6, 5'd10, 3'd0, 11'd0, 11'd0, 1'b1, 1'b0};
    for (int c = 0; c < 3; c++) begin
      total++;
      if (obs !== exp) begin
        bad++; $display("FAIL stall_cycle%0d got=%h exp=%h", c, obs, exp);
      end
      step();
    end
    flush = 1'b1;
    step();
    flush = 1'b0;
    total++;
    if ({out_valid, done, in_ready} !== 3'b001) begin
      bad++; $display("FAIL flush_t1 got=%b exp=001", {out_valid, done, in_ready});
    end
    step();
    total++;
    if ({out_valid, done, in_ready} !== 3'b001) begin
      bad++; $display("FAIL flush_t2 got=%b exp=001", {out_valid, done, in_ready});
    end
    out_ready = 1'b1;
  endtask

  task automatic test_flush_accept();
    flush = 1'b1;
    issue_instr(3'd1, 4'd2, 11'd16, 11'd0, 5'd2, 5'd3, 5'd4, 1'b0, 1'b0);
    flush = 1'b0;
    total++;
    if ({out_valid, done, in_ready} !== 3'b001) begin
      bad++; $display("FAIL flush_accept_t1 got=%b exp=001", {out_valid, done, in_ready});
    end
    step();
    total++;
    if ({out_valid, done, in_ready} !== 3'b001) begin
      bad++; $display("FAIL flush_accept_t2 got=%b exp=001", {out_valid, done, in_ready});
    end
  endtask

  task automatic test_back_to_back();
    logic [42:0] exp;
    issue_instr(3'd0, 4'd2, 11'd3, 11'd0, 5'd5, 5'd6, 5'd7, 1'b0, 1'b0);
    exp = {1'b1, 5'd5, 5'd6, 5'd7, 3'd0, 11'd0, 11'd0, 1'b1, 1'b1};
    total++;
    if (obs !== exp) begin
      bad++; $display("FAIL single_uop got=%h exp=%h", obs, exp);
    end
    step();
    total++;
    if ({done, in_ready, out_valid} !== 3'b110) begin
      bad++; $display("FAIL single_done got=%b exp=110", {done, in_ready, out_valid});
    end
    // accept in the same cycle as done; fractional vlmul acts as LMUL=1
    issue_instr(3'd4, 4'd2, 11'd5, 11'd0, 5'd7, 5'd8, 5'd9, 1'b0, 1'b0);
    exp = {1'b1, 5'd7, 5'd8, 5'd9, 3'd0, 11'd0, 11'd0, 1'b1, 1'b1};
    total++;
    if ({obs, done} !== {exp, 1'b0}) begin
      bad++; $display("FAIL b2b_uop got=%h exp=%h", {obs, done}, {exp, 1'b0});
    end
    step();
    total++;
    if ({done, out_valid} !== 2'b10) begin
      bad++; $display("FAIL b2b_done got=%b exp=10", {done, out_valid});
    end
    step();
  endtask

  task automatic test_wrap_reset();
    logic [42:0] exp;
    issue_instr(3'd2, 4'd2, 11'd16, 11'd0, 5'd30, 5'd3, 5'd30, 1'b0, 1'b1);
    for (int k = 0; k < 4; k++) begin
      exp = {1'b1, 5'd30, 5'(3 + k), 5'(30 + k), 3'(k), 11'(4 * k), 11'd0,
             (k == 0), (k == 3)};
      total++;
      if (obs !== exp) begin
        bad++; $display("FAIL wrap_uop%0d got=%h exp=%h", k, obs, exp);
      end
      if (k < 3) step();
    end
    rst = 1'b0;
    #1;
    total++;
    if ({obs, in_ready, done} !== {43'd0, 1'b1, 1'b0}) begin
      bad++; $display("FAIL async_reset got=%h exp=%h", {obs, in_ready, done},
                      {43'd0, 1'b1, 1'b0});
    end
    #1;
    rst = 1'b1;
    step();
    total++;
    if ({out_valid, done, in_ready} !== 3'b001) begin
      bad++; $display("FAIL after_reset got=%b exp=001", {out_valid, done, in_ready});
    end
  endtask

  initial begin
    test_reset();
    test_lmul4();
    test_vstart();
    test_reduct();
    test_empty();
    test_stall_flush();
    test_flush_accept();
    test_back_to_back();
    test_wrap_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/riscv_v_lmul_sequencer.md
Name: riscv_v_lmul_sequencer

Overview:
- Splits one decoded vector instruction with register grouping (LMUL = 1, 2, 4 or 8) into per-register micro-ops.
- Issues the micro-ops one at a time into the vector execute stage, with each micro-op's vd/vs1/vs2, the element offset it covers, and its local vstart.
- Sits between vector decode and the execute stage; it stalls decode while a sequence is in flight.
- Also resolves the vstart≠0 reduction case, which the execute stage does not support.

Parameters:
- ADDR_W, 5, vector register address width (32 registers).
- VL_W, 11, width of vl/vstart and element indices.
- ELOG_W, 4, width of the log2(elements-per-register) input.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-low (0 = reset)
- flush  in  1  synchronous kill of the current sequence
- in_valid  in  1  decode offers an instruction
- in_ready  out  1  sequencer can accept an instruction
- in_vlmul  in  3  vtype.vlmul; 0..3 = LMUL 1,2,4,8; 4..7 (fractional) treated as LMUL 1
- in_elog  in  ELOG_W  log2(VLEN/SEW), elements per register
- in_vl  in  VL_W  vl
- in_vstart  in  VL_W  vstart
- in_vd, in_vs1, in_vs2  in  ADDR_W each  base register addresses
- in_is_reduct  in  1  reduction: vd and vs1 are fixed, only vs2 steps
- in_is_mask  in  1  mask destination: vd is fixed
- out_valid  out  1  micro-op valid
- out_ready  in  1  execute accepts the micro-op
- out_vd, out_vs1, out_vs2  out  ADDR_W each  micro-op register addresses
- out_uop_idx  out  3  micro-op index k
- out_elem_base  out  VL_W  k << in_elog
- out_vstart  out  VL_W  local vstart of the micro-op
- out_first, out_last  out  1 each  first / last issued micro-op of the sequence
- done  out  1  one-cycle pulse when the sequence completes
- err_vstart_reduct  out  1  one-cycle pulse: reduction was accepted with vstart≠0

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; in_ready=1; out_valid=0; done=0; err_vstart_reduct=0; all address, index and vstart outputs = 0.
- States: IDLE, ISSUE.
  - in_ready = (state==IDLE).
  - Accept occurs when in_valid & in_ready; all in_* are latched at accept.
- Decisions made at the accept cycle t:
  - N = 1 << min(in_vlmul, 3), or N = 1 when in_vlmul ≥ 4.
  - E = 1 << in_elog.
  - vs = 0 if in_is_reduct, else in_vstart.
  - err_vstart_reduct pulses at t+1 when in_is_reduct & in_vstart≠0.
  - kf = vs >> in_elog.
  - kl = min(N−1, ((in_vl + E − 1) >> in_elog) − 1).
  - Empty case: if in_vl==0, or vs ≥ in_vl, or kf > kl, stay IDLE and pulse done at t+1; no micro-op is issued.
  - Otherwise go to ISSUE with k=kf; out_valid=1 at t+1 (one cycle of latency).
- ISSUE outputs for micro-op k:
  - out_vd = vd + k, except vd when is_mask or is_reduct.
  - out_vs1 = vs1 + k, except vs1 when is_reduct.
  - out_vs2 = vs2 + k.
  - All additions are modulo 2^ADDR_W and wrap silently; grouping legality is checked by decode, not here.
  - out_vstart = vs − (k<<in_elog) when k==kf, else 0.
  - out_first = (k==kf); out_last = (k==kl).
- Handshake:
  - All out_* hold stable while out_valid & !out_ready.
  - On out_valid & out_ready with k<kl: k increments and the next micro-op is presented the following cycle. Issue is back-to-back, with no bubble.
  - On out_valid & out_ready with k==kl: next cycle state=IDLE, out_valid=0, done=1 for one cycle, in_ready=1. A new accept is legal in that same cycle.
- Flush:
  - flush=1 forces state=IDLE and out_valid=0 next cycle, with no done pulse. It has priority over handshake and accept.
  - A flush coinciding with an accept discards that instruction.
- Reset asserted mid-sequence returns immediately to the reset values. The sequence is lost; no done pulse.
- Single-register case: LMUL=1 with a nonzero in-range vl issues exactly one micro-op with out_first=out_last=1.

Test Plan:
- LMUL=4, elog=2, vl=16, vstart=0, vd=8, vs1=4, vs2=12, out_ready=1 → 4 consecutive micro-ops: vd 8..11, vs1 4..7, vs2 12..15, elem_base 0,4,8,12; done at cycle t+5.
- LMUL=8, elog=3, vl=20, vstart=10 → micro-ops k=1,2 only. k=1 has out_vstart=2 and first=1; k=2 has out_vstart=0 and last=1.
- Reduction: LMUL=2, vstart=5, vd=1, vs1=2, vs2=30 → err_vstart_reduct pulses; micro-ops have vd=1, vs1=2 (fixed), vs2=30 then 31, local vstart 0.
- vl=0 → no out_valid, done pulses at t+1, in_ready stays 1.
- LMUL=2, out_ready held low 3 cycles on micro-op 0 → outputs stable for those cycles. Flush on the 4th cycle → out_valid=0 next cycle, no done pulse.
- Address wrap: LMUL=4, vd=30, mask dest → vs2 = 30,31,0,1 (vs2 base 30); vd stays 30. rst pulled low mid-sequence → out_valid=0 immediately.
